// File: rtl/router_pkg.sv
// Shared router types: flit encodings, per-VC state and flit field positions.
package router_pkg;

  localparam int PORT_W = 3;

  // Field positions counted down from the flit width:
  // type MSB sits at FLIT_W-FLIT_TYPE_MSB, route LSB at FLIT_W-ROUTE_FIELD_LSB.
  localparam int FLIT_TYPE_MSB   = 1;
  localparam int ROUTE_FIELD_LSB = 5;

  typedef enum logic [1:0] {
    FT_BODY      = 2'b00,
    FT_TAIL      = 2'b01,
    FT_HEAD      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    VC_IDLE    = 2'b00,
    VC_ROUTING = 2'b01,
    VC_ACTIVE  = 2'b10
  } vc_state_t;

  function automatic logic is_head(input flit_type_t t);
    return (t == FT_HEAD) || (t == FT_HEAD_TAIL);
  endfunction

  function automatic logic is_tail(input flit_type_t t);
    return (t == FT_TAIL) || (t == FT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/vc_flit_fifo.sv
// Per-VC flit buffer: synchronous write/read with a show-ahead front output.
// A write while full is legal only together with a read (caller guarantees it).
module vc_flit_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         front,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; depth is a power of 2 so pointers wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign front = mem[rd_ptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/vc_input_unit.sv
// Router input port: per-VC flit buffering, head-flit route decode,
// switch-allocation requests, granted flit forwarding and credit return.
module vc_input_unit
  import router_pkg::*;
#(
  parameter int FLIT_W    = 34,
  parameter int NUM_VC    = 2,
  parameter int VC_DEPTH  = 4,
  parameter int NUM_PORTS = 5,
  localparam int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_flit_valid,
  input  logic [FLIT_W-1:0]          i_flit,
  input  logic [VC_W-1:0]            i_flit_vc,
  output logic                       o_credit_valid,
  output logic [VC_W-1:0]            o_credit_vc,
  output logic [NUM_VC-1:0]          o_sa_req,
  output logic [NUM_VC*PORT_W-1:0]   o_sa_port,
  input  logic [NUM_VC-1:0]          i_sa_gnt,
  output logic                       o_flit_valid,
  output logic [FLIT_W-1:0]          o_flit,
  output logic [VC_W-1:0]            o_flit_vc,
  output logic [NUM_VC-1:0]          o_vc_busy,
  output logic                       o_err
);

  localparam int CNT_W    = $clog2(VC_DEPTH) + 1;
  localparam int TYPE_HI  = FLIT_W - FLIT_TYPE_MSB;
  localparam int ROUTE_LO = FLIT_W - ROUTE_FIELD_LSB;

  logic [NUM_VC-1:0][FLIT_W-1:0] front;
  logic [NUM_VC-1:0][CNT_W-1:0]  count;
  flit_type_t [NUM_VC-1:0]       ftype;
  logic [NUM_VC-1:0]             full, empty, wr_en, pop, stray, sa_req, bad_port;
  logic [NUM_VC-1:0][PORT_W-1:0] route_q, route_nxt;
  vc_state_t                     state_q   [NUM_VC];
  vc_state_t                     state_nxt [NUM_VC];
  logic                          gnt_onehot, gnt_ok, gnt_bad, pop_any, wr_drop, vc_hit;
  logic [VC_W-1:0]               gnt_idx, pop_idx;
  flit_type_t                    in_type;
  logic [PORT_W-1:0]             port_field;
  logic                          err_now;

  assign in_type = flit_type_t'(i_flit[TYPE_HI -: 2]);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_flit_fifo #(.WIDTH(FLIT_W), .DEPTH(VC_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en[v]),
      .wr_data (i_flit),
      .rd_en   (pop[v]),
      .front   (front[v]),
      .full    (full[v]),
      .empty   (empty[v]),
      .count   (count[v])
    );
    assign ftype[v] = flit_type_t'(front[v][TYPE_HI -: 2]);
  end

  // Requests, grant validation and the single pop slot (grant beats stray drop).
  always_comb begin
    sa_req  = '0;
    stray   = '0;
    gnt_idx = '0;
    pop_idx = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      sa_req[v] = (state_q[v] == VC_ACTIVE) && !empty[v];
      stray[v]  = (state_q[v] == VC_IDLE) && !empty[v] && !is_head(ftype[v]);
    end
    gnt_onehot = (i_sa_gnt != '0) && ((i_sa_gnt & (i_sa_gnt - NUM_VC'(1))) == '0);
    gnt_ok     = gnt_onehot && ((i_sa_gnt & sa_req) != '0);
    gnt_bad    = (i_sa_gnt != '0) && !gnt_ok;
    pop        = gnt_ok ? i_sa_gnt : '0;
    if (!gnt_ok) begin
      // lowest-numbered stray VC takes the free slot
      for (int v = NUM_VC - 1; v >= 0; v--) begin
        if (stray[v]) begin
          pop    = '0;
          pop[v] = 1'b1;
        end
      end
    end
    pop_any = |pop;
    for (int v = 0; v < NUM_VC; v++) begin
      if (i_sa_gnt[v]) gnt_idx = VC_W'(v);
      if (pop[v])      pop_idx = VC_W'(v);
    end
  end

  // Write steering: a full FIFO only accepts when it is popped the same cycle.
  always_comb begin
    wr_en   = '0;
    wr_drop = 1'b0;
    vc_hit  = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (i_flit_vc == VC_W'(v)) begin
        vc_hit = 1'b1;
        if (i_flit_valid) begin
          if (full[v] && !pop[v]) wr_drop  = 1'b1;
          else                    wr_en[v] = (count[v] != CNT_W'(VC_DEPTH)) || pop[v];
        end
      end
    end
    if (i_flit_valid && !vc_hit) wr_drop = 1'b1;
  end

  // Per-VC packet FSM next state and route decode.
  always_comb begin
    route_nxt  = route_q;
    bad_port   = '0;
    port_field = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      state_nxt[v] = state_q[v];
      case (state_q[v])
        VC_IDLE: begin
          // an incoming head on an empty FIFO starts routing straight away
          if (!empty[v] && is_head(ftype[v]))
            state_nxt[v] = VC_ROUTING;
          else if (empty[v] && wr_en[v] && is_head(in_type))
            state_nxt[v] = VC_ROUTING;
        end
        VC_ROUTING: begin
          port_field = front[v][ROUTE_LO +: PORT_W];
          if (int'(port_field) >= NUM_PORTS) begin
            route_nxt[v] = '0;
            bad_port[v]  = 1'b1;
          end else begin
            route_nxt[v] = port_field;
          end
          state_nxt[v] = VC_ACTIVE;
        end
        VC_ACTIVE: begin
          if (pop[v] && is_tail(ftype[v])) state_nxt[v] = VC_IDLE;
        end
        default: state_nxt[v] = VC_IDLE;
      endcase
    end
  end

  // Per-VC state and route registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= VC_IDLE;
      route_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= state_nxt[v];
      route_q <= route_nxt;
    end
  end

  assign err_now = wr_drop | gnt_bad | (pop_any & !gnt_ok) | (|bad_port);

  // Registered crossbar, credit and sticky error outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_flit_valid   <= 1'b0;
      o_flit         <= '0;
      o_flit_vc      <= '0;
      o_credit_valid <= 1'b0;
      o_credit_vc    <= '0;
      o_err          <= 1'b0;
    end else begin
      o_flit_valid   <= gnt_ok;
      o_credit_valid <= pop_any;
      o_err          <= o_err | err_now;
      if (gnt_ok) begin
        o_flit    <= front[gnt_idx];
        o_flit_vc <= gnt_idx;
      end
      if (pop_any) o_credit_vc <= pop_idx;
    end
  end

  // Allocator-facing view of the per-VC state.
  always_comb begin
    o_sa_port = '0;
    o_vc_busy = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      o_vc_busy[v] = (state_q[v] != VC_IDLE);
      if (state_q[v] == VC_ACTIVE) o_sa_port[v*PORT_W +: PORT_W] = route_q[v];
    end
  end

  assign o_sa_req = sa_req;

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed bench for vc_input_unit with default parameters (2 VCs, depth 4).
module tb_vc_input_unit;

  localparam logic [1:0] HD = 2'b10, BD = 2'b00, TL = 2'b01, HT = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_flit_valid = 1'b0;
  logic [33:0] i_flit = '0;
  logic [0:0]  i_flit_vc = '0;
  logic        o_credit_valid;
  logic [0:0]  o_credit_vc;
  logic [1:0]  o_sa_req;
  logic [5:0]  o_sa_port;
  logic [1:0]  i_sa_gnt = '0;
  logic        o_flit_valid;
  logic [33:0] o_flit;
  logic [0:0]  o_flit_vc;
  logic [1:0]  o_vc_busy;
  logic        o_err;

  int vecs = 0;
  int errs = 0;

  vc_input_unit #(.FLIT_W(34), .NUM_VC(2), .VC_DEPTH(4), .NUM_PORTS(5)) dut (
    .clk(clk), .reset_n(reset_n), .i_flit_valid(i_flit_valid), .i_flit(i_flit),
    .i_flit_vc(i_flit_vc), .o_credit_valid(o_credit_valid), .o_credit_vc(o_credit_vc),
    .o_sa_req(o_sa_req), .o_sa_port(o_sa_port), .i_sa_gnt(i_sa_gnt),
    .o_flit_valid(o_flit_valid), .o_flit(o_flit), .o_flit_vc(o_flit_vc),
    .o_vc_busy(o_vc_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] mk(input logic [1:0] t, input logic [2:0] p, input logic [28:0] pl);
    return {t, p, pl};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_flit(input logic vc, input logic [33:0] f);
    i_flit_valid = 1'b1;
    i_flit       = f;
    i_flit_vc    = vc;
    tick();
    i_flit_valid = 1'b0;
  endtask

  task automatic apply_reset;
    i_flit_valid = 1'b0;
    i_sa_gnt     = '0;
    reset_n      = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    #2;
    vecs++;
    if ({o_credit_valid, o_credit_vc, o_sa_req, o_sa_port, o_flit_valid, o_flit, o_flit_vc, o_vc_busy, o_err} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got req=%b port=%h busy=%b err=%b fv=%b cv=%b, want all 0",
               o_sa_req, o_sa_port, o_vc_busy, o_err, o_flit_valid, o_credit_valid);
    end
    apply_reset();
  endtask

  task automatic test_single;
    logic [33:0] f;
    f = mk(HT, 3'd3, 29'h0abc);
    drive_flit(1'b0, f);                              // cycle 1
    vecs++;
    if (o_vc_busy !== 2'b01 || o_sa_req !== 2'b00) begin
      errs++; $display("FAIL single_routing: busy=%b req=%b want busy=01 req=00", o_vc_busy, o_sa_req);
    end
    tick();                                           // cycle 2
    vecs++;
    if (o_sa_req !== 2'b01 || o_sa_port[2:0] !== 3'd3) begin
      errs++; $display("FAIL single_req: req=%b port=%0d want req=01 port=3", o_sa_req, o_sa_port[2:0]);
    end
    tick();                                           // cycle 3
    i_sa_gnt = 2'b01;
    tick();                                           // cycle 4
    i_sa_gnt = 2'b00;
    vecs++;
    if (o_flit_valid !== 1'b1 || o_flit !== f || o_flit_vc !== 1'b0) begin
      errs++; $display("FAIL single_fwd: v=%b flit=%h vc=%b want 1/%h/0", o_flit_valid, o_flit, o_flit_vc, f);
    end
    vecs++;
    if (o_credit_valid !== 1'b1 || o_credit_vc !== 1'b0 || o_vc_busy !== 2'b00 || o_sa_req !== 2'b00) begin
      errs++; $display("FAIL single_credit: cv=%b cvc=%b busy=%b req=%b want 1/0/00/00",
                       o_credit_valid, o_credit_vc, o_vc_busy, o_sa_req);
    end
    tick();
    vecs++;
    if (o_flit_valid !== 1'b0 || o_credit_valid !== 1'b0 || o_err !== 1'b0) begin
      errs++; $display("FAIL single_after: fv=%b cv=%b err=%b want 0/0/0", o_flit_valid, o_credit_valid, o_err);
    end
  endtask

  task automatic test_interleaved;
    logic [33:0] f0 [4];
    logic [33:0] f1 [4];
    logic [33:0] exp_f;
    logic        vc;
    int          crs;
    f0[0] = mk(HD, 3'd1, 29'h100); f0[1] = mk(BD, 3'd0, 29'h101);
    f0[2] = mk(BD, 3'd0, 29'h102); f0[3] = mk(TL, 3'd0, 29'h103);
    f1[0] = mk(HD, 3'd4, 29'h200); f1[1] = mk(BD, 3'd0, 29'h201);
    f1[2] = mk(BD, 3'd0, 29'h202); f1[3] = mk(TL, 3'd0, 29'h203);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_flit(1'b0, f0[i]);
      drive_flit(1'b1, f1[i]);
    end
    tick();
    vecs++;
    if (o_sa_req !== 2'b11 || o_sa_port !== 6'b100_001) begin
      errs++; $display("FAIL inter_req: req=%b port=%b want 11/100001", o_sa_req, o_sa_port);
    end
    crs = 0;
    for (int k = 0; k < 8; k++) begin
      vc       = (k % 2) == 1;
      exp_f    = vc ? f1[k/2] : f0[k/2];
      i_sa_gnt = vc ? 2'b10 : 2'b01;
      tick();
      i_sa_gnt = 2'b00;
      if (o_credit_valid === 1'b1) crs++;
      vecs++;
      if (o_flit_valid !== 1'b1 || o_flit !== exp_f || o_flit_vc !== vc || o_credit_vc !== vc) begin
        errs++; $display("FAIL inter_fwd%0d: v=%b flit=%h vc=%b cvc=%b want 1/%h/%b/%b",
                         k, o_flit_valid, o_flit, o_flit_vc, o_credit_vc, exp_f, vc, vc);
      end
    end
    tick();
    vecs++;
    if (crs != 8 || o_vc_busy !== 2'b00 || o_sa_req !== 2'b00 || o_err !== 1'b0) begin
      errs++; $display("FAIL inter_end: credits=%0d busy=%b req=%b err=%b want 8/00/00/0", crs, o_vc_busy, o_sa_req, o_err);
    end
  endtask

  task automatic test_full;
    logic [33:0] f [5];
    f[0] = mk(HD, 3'd2, 29'h300); f[1] = mk(BD, 3'd0, 29'h301);
    f[2] = mk(BD, 3'd0, 29'h302); f[3] = mk(BD, 3'd0, 29'h303);
    f[4] = mk(TL, 3'd0, 29'h304);
    apply_reset();
    for (int i = 0; i < 4; i++) drive_flit(1'b1, f[i]);
    tick();
    vecs++;
    if (o_err !== 1'b0 || o_sa_req !== 2'b10 || o_sa_port[5:3] !== 3'd2) begin
      errs++; $display("FAIL full_fill: err=%b req=%b port=%0d want 0/10/2", o_err, o_sa_req, o_sa_port[5:3]);
    end
    drive_flit(1'b1, f[4]);
    vecs++;
    if (o_err !== 1'b1 || o_credit_valid !== 1'b0 || o_flit_valid !== 1'b0) begin
      errs++; $display("FAIL full_overflow: err=%b cv=%b fv=%b want 1/0/0", o_err, o_credit_valid, o_flit_valid);
    end
    apply_reset();
    for (int i = 0; i < 4; i++) drive_flit(1'b1, f[i]);
    i_flit_valid = 1'b1; i_flit = f[4]; i_flit_vc = 1'b1; i_sa_gnt = 2'b10;
    tick();
    i_flit_valid = 1'b0; i_sa_gnt = 2'b00;
    vecs++;
    if (o_err !== 1'b0 || o_flit_valid !== 1'b1 || o_flit !== f[0]) begin
      errs++; $display("FAIL full_wr_pop: err=%b fv=%b flit=%h want 0/1/%h", o_err, o_flit_valid, o_flit, f[0]);
    end
    for (int i = 1; i < 5; i++) begin
      i_sa_gnt = 2'b10;
      tick();
      i_sa_gnt = 2'b00;
      vecs++;
      if (o_flit_valid !== 1'b1 || o_flit !== f[i] || o_credit_vc !== 1'b1) begin
        errs++; $display("FAIL full_drain%0d: fv=%b flit=%h cvc=%b want 1/%h/1", i, o_flit_valid, o_flit, o_credit_vc, f[i]);
      end
    end
    vecs++;
    if (o_vc_busy !== 2'b00 || o_err !== 1'b0) begin
      errs++; $display("FAIL full_end: busy=%b err=%b want 00/0", o_vc_busy, o_err);
    end
  endtask

  task automatic test_stray;
    apply_reset();
    drive_flit(1'b0, mk(BD, 3'd0, 29'h400));          // cycle 1
    vecs++;
    if (o_credit_valid !== 1'b0 || o_err !== 1'b0) begin
      errs++; $display("FAIL stray_early: cv=%b err=%b want 0/0", o_credit_valid, o_err);
    end
    tick();                                           // cycle 2
    vecs++;
    if (o_credit_valid !== 1'b1 || o_credit_vc !== 1'b0 || o_err !== 1'b1 || o_sa_req !== 2'b00) begin
      errs++; $display("FAIL stray_drop: cv=%b cvc=%b err=%b req=%b want 1/0/1/00",
                       o_credit_valid, o_credit_vc, o_err, o_sa_req);
    end
    tick();
    vecs++;
    if (o_credit_valid !== 1'b0 || o_vc_busy !== 2'b00 || o_flit_valid !== 1'b0) begin
      errs++; $display("FAIL stray_after: cv=%b busy=%b fv=%b want 0/00/0", o_credit_valid, o_vc_busy, o_flit_valid);
    end
  endtask

  task automatic test_bad_grant;
    logic [1:0] bad [2];
    bad[0] = 2'b11;
    bad[1] = 2'b10;
    for (int i = 0; i < 2; i++) begin
      apply_reset();
      drive_flit(1'b0, mk(HD, 3'd1, 29'h500));
      drive_flit(1'b0, mk(BD, 3'd0, 29'h501));
      tick();
      vecs++;
      if (o_sa_req !== 2'b01) begin
        errs++; $display("FAIL badgnt_req%0d: req=%b want 01", i, o_sa_req);
      end
      i_sa_gnt = bad[i];
      tick();
      i_sa_gnt = 2'b00;
      vecs++;
      if (o_flit_valid !== 1'b0 || o_credit_valid !== 1'b0 || o_err !== 1'b1 || o_sa_req !== 2'b01) begin
        errs++; $display("FAIL badgnt_%b: fv=%b cv=%b err=%b req=%b want 0/0/1/01",
                         bad[i], o_flit_valid, o_credit_valid, o_err, o_sa_req);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [33:0] f [4];
    f[0] = mk(HD, 3'd4, 29'h600); f[1] = mk(BD, 3'd0, 29'h601);
    f[2] = mk(BD, 3'd0, 29'h602); f[3] = mk(TL, 3'd0, 29'h603);
    apply_reset();
    drive_flit(1'b0, mk(HD, 3'd2, 29'h5f0));
    drive_flit(1'b0, mk(BD, 3'd0, 29'h5f1));
    vecs++;
    if (o_vc_busy !== 2'b01) begin
      errs++; $display("FAIL rstmid_busy: busy=%b want 01", o_vc_busy);
    end
    reset_n = 1'b0;
    #1;
    vecs++;
    if ({o_credit_valid, o_credit_vc, o_sa_req, o_sa_port, o_flit_valid, o_flit, o_flit_vc, o_vc_busy, o_err} !== '0) begin
      errs++; $display("FAIL rstmid_outputs: req=%b port=%h busy=%b err=%b want all 0", o_sa_req, o_sa_port, o_vc_busy, o_err);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    vecs++;
    if (o_credit_valid !== 1'b0 || o_vc_busy !== 2'b00) begin
      errs++; $display("FAIL rstmid_nocredit: cv=%b busy=%b want 0/00", o_credit_valid, o_vc_busy);
    end
    for (int i = 0; i < 4; i++) drive_flit(1'b0, f[i]);
    vecs++;
    if (o_err !== 1'b0 || o_sa_req !== 2'b01 || o_sa_port[2:0] !== 3'd4) begin
      errs++; $display("FAIL rstmid_refill: err=%b req=%b port=%0d want 0/01/4", o_err, o_sa_req, o_sa_port[2:0]);
    end
    for (int i = 0; i < 4; i++) begin
      i_sa_gnt = 2'b01;
      tick();
      i_sa_gnt = 2'b00;
      vecs++;
      if (o_flit_valid !== 1'b1 || o_flit !== f[i] || o_credit_valid !== 1'b1) begin
        errs++; $display("FAIL rstmid_drain%0d: fv=%b flit=%h cv=%b want 1/%h/1", i, o_flit_valid, o_flit, o_credit_valid, f[i]);
      end
    end
    tick();
    vecs++;
    if (o_credit_valid !== 1'b0 || o_vc_busy !== 2'b00 || o_err !== 1'b0) begin
      errs++; $display("FAIL rstmid_end: cv=%b busy=%b err=%b want 0/00/0", o_credit_valid, o_vc_busy, o_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_interleaved();
    test_full();
    test_stray();
    test_bad_grant();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
